// File: rtl/regfile_bypass_sb.sv
// Parametrised two-read/one-write register file with optional write-to-read forwarding
// and a per-register pending-write scoreboard for RAW hazard detection in decode.
module regfile_bypass_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    output logic              raw_hazard,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic [ADDR_W:0]   busy_count
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busyNext;
    logic [ADDR_W:0]   busyCount;
    logic [ADDR_W:0]   countNext;

    logic wrValid;
    logic issueValid;
    logic hit1;
    logic hit2;
    logic zero1;
    logic zero2;

    assign wrValid    = wr_en    && !((ZERO_REG != 0) && (wr_addr    == '0));
    assign issueValid = issue_en && !((ZERO_REG != 0) && (issue_addr == '0));

    // Clear before set so a new producer issued in the writeback cycle keeps the register reserved.
    always_comb begin
        busyNext = busy;
        if (wr_en)
            busyNext[wr_addr] = 1'b0;
        if (issueValid)
            busyNext[issue_addr] = 1'b1;
        countNext = '0;
        for (int i = 0; i < NREGS; i++)
            countNext = countNext + {{ADDR_W{1'b0}}, busyNext[i]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
            busy      <= '0;
            busyCount <= '0;
        end else begin
            if (wrValid)
                regs[wr_addr] <= wr_data;
            busy      <= busyNext;
            busyCount <= countNext;
        end
    end

    assign hit1  = (BYPASS != 0) && wr_en && (wr_addr == rd_addr1);
    assign hit2  = (BYPASS != 0) && wr_en && (wr_addr == rd_addr2);
    assign zero1 = (ZERO_REG != 0) && (rd_addr1 == '0);
    assign zero2 = (ZERO_REG != 0) && (rd_addr2 == '0);

    // rst gating keeps a forwarded wr_data from leaking out while reset is held.
    assign rd_data1 = (rst || zero1) ? '0 : (hit1 ? wr_data : regs[rd_addr1]);
    assign rd_data2 = (rst || zero2) ? '0 : (hit2 ? wr_data : regs[rd_addr2]);

    assign rd_busy1   = !rst && !zero1 && busy[rd_addr1] && !hit1;
    assign rd_busy2   = !rst && !zero2 && busy[rd_addr2] && !hit2;
    assign raw_hazard = rd_busy1 | rd_busy2;
    assign busy_count = busyCount;

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Bench for regfile_bypass_sb: forwarding and non-forwarding builds share stimulus and are
// checked every cycle against an array model; a 32x32 build gets directed checks.
module tb_regfile_bypass_sb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  rd_addr1 = '0, rd_addr2 = '0, wr_addr = '0, issue_addr = '0;
    logic [15:0] wr_data = '0;
    logic        wr_en = 1'b0, issue_en = 1'b0;

    logic [15:0] aData1, aData2, bData1, bData2;
    logic        aBusy1, aBusy2, aRaw, bBusy1, bBusy2, bRaw;
    logic [4:0]  aCount, bCount;

    logic [4:0]  cRdAddr1 = '0, cRdAddr2 = '0, cWrAddr = '0, cIssueAddr = '0;
    logic [31:0] cWrData = '0;
    logic        cWrEn = 1'b0, cIssueEn = 1'b0;
    logic [31:0] cData1, cData2;
    logic        cBusy1, cBusy2, cRaw;
    logic [5:0]  cCount;

    int tests = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_bypass_sb #(.DATA_W(16), .ADDR_W(4), .BYPASS(1), .ZERO_REG(1)) dutA (
        .clk(clk), .rst(rst), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(aData1), .rd_data2(aData2), .rd_busy1(aBusy1), .rd_busy2(aBusy2),
        .raw_hazard(aRaw), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .busy_count(aCount));

    regfile_bypass_sb #(.DATA_W(16), .ADDR_W(4), .BYPASS(0), .ZERO_REG(1)) dutB (
        .clk(clk), .rst(rst), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(bData1), .rd_data2(bData2), .rd_busy1(bBusy1), .rd_busy2(bBusy2),
        .raw_hazard(bRaw), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .busy_count(bCount));

    regfile_bypass_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1), .ZERO_REG(1)) dutC (
        .clk(clk), .rst(rst), .rd_addr1(cRdAddr1), .rd_addr2(cRdAddr2),
        .rd_data1(cData1), .rd_data2(cData2), .rd_busy1(cBusy1), .rd_busy2(cBusy2),
        .raw_hazard(cRaw), .wr_en(cWrEn), .wr_addr(cWrAddr), .wr_data(cWrData),
        .issue_en(cIssueEn), .issue_addr(cIssueAddr), .busy_count(cCount));

    // Architectural model of the 16x16 file: contents and set of reserved registers.
    logic [15:0] mReg  [16];
    bit          mBusy [16];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                mReg[i]  = '0;
                mBusy[i] = 0;
            end
        end else begin
            if (wr_en && wr_addr != 0) mReg[wr_addr] = wr_data;
            if (wr_en) mBusy[wr_addr] = 0;
            if (issue_en && issue_addr != 0) mBusy[issue_addr] = 1;
        end
    end

    function automatic logic [15:0] expData(input logic [3:0] a, input bit byp);
        if (rst || a == 0) return 16'h0000;
        if (byp && wr_en && wr_addr == a) return wr_data;
        return mReg[a];
    endfunction

    function automatic bit expBusy(input logic [3:0] a, input bit byp);
        if (rst || a == 0) return 0;
        if (byp && wr_en && wr_addr == a) return 0;
        return mBusy[a];
    endfunction

    function automatic int expCount();
        int n = 0;
        for (int i = 0; i < 16; i++) n += mBusy[i] ? 1 : 0;
        return n;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("A.rd_data1", aData1, expData(rd_addr1, 1));
        check("A.rd_data2", aData2, expData(rd_addr2, 1));
        check("A.rd_busy1", aBusy1, expBusy(rd_addr1, 1));
        check("A.rd_busy2", aBusy2, expBusy(rd_addr2, 1));
        check("A.raw_hazard", aRaw, expBusy(rd_addr1, 1) | expBusy(rd_addr2, 1));
        check("A.busy_count", aCount, expCount());
        check("B.rd_data1", bData1, expData(rd_addr1, 0));
        check("B.rd_data2", bData2, expData(rd_addr2, 0));
        check("B.rd_busy1", bBusy1, expBusy(rd_addr1, 0));
        check("B.rd_busy2", bBusy2, expBusy(rd_addr2, 0));
        check("B.raw_hazard", bRaw, expBusy(rd_addr1, 0) | expBusy(rd_addr2, 0));
        check("B.busy_count", bCount, expCount());
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            rd_addr1 = 4'(i);
            rd_addr2 = 4'(15 - i);
            settle();
            check("reset.read1", aData1, 16'h0000);
            check("reset.read2", aData2, 16'h0000);
            tick();
        end
        check("reset.count", aCount, 5'd0);

        wr_en = 1; wr_addr = 4'd5; wr_data = 16'hBEEF; rd_addr1 = 0; rd_addr2 = 0;
        tick();
        wr_en = 0; rd_addr1 = 4'd5; rd_addr2 = 4'd5;
        settle();
        check("R5.port1", aData1, 16'hBEEF);
        check("R5.port2", aData2, 16'hBEEF);
        tick();

        wr_en = 1; wr_addr = 4'd0; wr_data = 16'h1234; rd_addr1 = 0;
        settle();
        check("R0.bypassed", aData1, 16'h0000);
        tick();
        wr_en = 0;
        settle();
        check("R0.stored", aData1, 16'h0000);
        tick();

        wr_en = 1; wr_addr = 4'd7; wr_data = 16'hA5A5; rd_addr2 = 4'd7;
        settle();
        check("bypass.on", aData2, 16'hA5A5);
        check("bypass.off", bData2, 16'h0000);
        tick();
        wr_en = 0;
        settle();
        check("R7.after", bData2, 16'hA5A5);
        tick();

        issue_en = 1; issue_addr = 4'd3; rd_addr1 = 4'd3; rd_addr2 = 4'd5;
        settle();
        check("issue.same_cycle", aBusy1, 1'b0);
        tick();
        issue_en = 0;
        settle();
        check("R3.busy", aBusy1, 1'b1);
        check("R3.raw", aRaw, 1'b1);
        check("R3.count", aCount, 5'd1);
        tick();
        wr_en = 1; wr_addr = 4'd3; wr_data = 16'h0042;
        settle();
        check("R3.wb.busyA", aBusy1, 1'b0);
        check("R3.wb.dataA", aData1, 16'h0042);
        check("R3.wb.busyB", bBusy1, 1'b1);
        check("R3.wb.dataB", bData1, 16'h0000);
        tick();
        wr_en = 0;
        settle();
        check("R3.released", aCount, 5'd0);
        tick();

        issue_en = 1; issue_addr = 4'd9; wr_en = 1; wr_addr = 4'd9; wr_data = 16'h0099;
        tick();
        issue_en = 0; wr_en = 0; rd_addr1 = 4'd9;
        settle();
        check("R9.data", aData1, 16'h0099);
        check("R9.busy", aBusy1, 1'b1);
        check("R9.count", aCount, 5'd1);
        tick();
        issue_en = 1; issue_addr = 4'd0;
        tick();
        issue_en = 0; rd_addr2 = 4'd0;
        settle();
        check("R0.issue.count", aCount, 5'd1);
        check("R0.issue.busy", aBusy2, 1'b0);
        tick();

        for (int i = 0; i < 40; i++) begin
            wr_en      = $urandom_range(0, 1) == 1;
            wr_addr    = 4'($urandom_range(0, 15));
            wr_data    = 16'($urandom);
            issue_en   = $urandom_range(0, 2) != 0;
            issue_addr = (i % 5 == 0) ? wr_addr : 4'($urandom_range(0, 15));
            rd_addr1   = (i % 3 == 0) ? wr_addr : 4'($urandom_range(0, 15));
            rd_addr2   = 4'($urandom_range(0, 15));
            tick();
        end
        wr_en = 0; issue_en = 0;

        cWrEn = 1; cWrAddr = 5'd31; cWrData = 32'hDEADBEEF;
        tick();
        cWrEn = 0; cIssueEn = 1;
        for (int i = 1; i < 32; i++) begin
            cIssueAddr = 5'(i);
            tick();
        end
        cIssueAddr = 5'd0;
        tick();
        cIssueEn = 0; cRdAddr1 = 5'd31; cRdAddr2 = 5'd0;
        settle();
        check("C.count", cCount, 6'd31);
        check("C.data31", cData1, 32'hDEADBEEF);
        check("C.busy31", cBusy1, 1'b1);
        check("C.data0", cData2, 32'h0);
        check("C.busy0", cBusy2, 1'b0);
        check("C.raw", cRaw, 1'b1);
        tick();

        wr_en = 1; wr_addr = 4'd5; wr_data = 16'h5555; issue_en = 1; issue_addr = 4'd6;
        tick();
        wr_en = 0; issue_en = 0; rd_addr1 = 4'd5; rd_addr2 = 4'd6;
        settle();
        check("pre_rst.data", aData1, 16'h5555);
        check("pre_rst.busy", aBusy2, 1'b1);
        tick();
        rst = 1; wr_en = 1; wr_addr = 4'd5; wr_data = 16'h7777;
        settle();
        check("rst.data", aData1, 16'h0000);
        check("rst.busy", aBusy2, 1'b0);
        check("rst.count", aCount, 5'd0);
        check("rst.C.count", cCount, 6'd0);
        tick();
        rst = 0; wr_en = 0;
        settle();
        check("post_rst.data", aData1, 16'h0000);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
